capture_ctrl: RTL and testbench
===============================

# capture_ctrl

Write-side controller for the sample RAM queue. It accepts an 8-bit sample stream with a strobe and runs a fill / armed / post-trigger capture sequence. It drives the queue's write port with a circular address that wraps at ENTRIES. It reports when a capture is complete and where the oldest sample sits, so readout can unroll the circular buffer.

## Interface
- ENTRIES, 384, depth of the downstream sample queue
- LOG2, 9, address width; ENTRIES <= 2**LOG2
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  single-cycle start/restart pulse
- post_len  in  LOG2  post-trigger sample count; sampled only on the cycle run is accepted
- smpl_en  in  1  sample-valid strobe from the decimator
- smpl  in  8  sample data, valid when smpl_en=1
- trig  in  1  trigger event, level-qualified each cycle
- we  out  1  queue write enable
- waddr  out  LOG2  queue write address
- wdata  out  8  queue write data
- armed  out  1  high while in ARMED
- capture_done  out  1  high in DONE
- oldest_addr  out  LOG2  address of the oldest valid sample, valid while capture_done=1
- trig_cnt  out  16  samples written while ARMED (see Configuration)

## Operation
- States: IDLE, FILL, ARMED, POST, DONE.
- IDLE
  - No writes.
  - run -> FILL.
  - On acceptance: waddr pointer=0, fill_cnt=0, post_len latched.
  - post_len > ENTRIES-1 is clamped to ENTRIES-1.
- FILL
  - Each smpl_en writes smpl at the pointer, then increments the pointer and fill_cnt.
  - trig is ignored.
  - When fill_cnt reaches ENTRIES - post_len_latched -> ARMED. This guarantees a full pre-trigger history.
- ARMED
  - Each smpl_en writes and increments the pointer.
  - trig=1 -> POST, post_cnt=0.
  - If trig and smpl_en coincide, that sample is written and counts as the first post-trigger sample (post_cnt=1).
  - If post_len_latched=0, trig goes directly to DONE. A coincident sample is still written.
- POST
  - Each smpl_en writes, increments the pointer and post_cnt.
  - When post_cnt reaches post_len_latched -> DONE.
  - Further trig pulses are ignored.
- DONE
  - No writes.
  - oldest_addr = the pointer value (the next slot to be overwritten, which holds the oldest sample).
  - run -> FILL with a fresh start, identical to IDLE acceptance.
- run in FILL/ARMED/POST restarts to FILL immediately. Pointer and counters are cleared; post_len is re-latched.
- Pointer arithmetic: the increment from ENTRIES-1 goes to 0, never to ENTRIES..2**LOG2-1. waddr never exceeds ENTRIES-1.

## Timing
- Reset values: we=0, waddr=0, wdata=0, armed=0, capture_done=0, oldest_addr=0, trig_cnt=0, state=IDLE.
- Write latency is 1 cycle: smpl_en/smpl at edge N -> we=1 with waddr/wdata presented during cycle N+1, for exactly one cycle per strobe.
- Back-to-back smpl_en every cycle is supported; we stays high continuously.
- State flags are registered and change on the edge that performs the transition.
- capture_done rises on the same edge that registers the final POST write. It stays high until run or rst.
- Reset asserted mid-capture returns all outputs to reset values asynchronously. No write is issued after rst rises.

## Configuration
- CAPT_TRIG_CNT_EN defined:
  - trig_cnt counts smpl_en writes made while in ARMED, including a write coincident with trig.
  - It saturates at 16'hFFFF, clears on run acceptance, and holds through POST and DONE.
- Not defined: trig_cnt is tied to 0 and the counter is not built.

## Test plan
- ENTRIES=384, post_len=100, smpl_en every cycle, trig one cycle after armed:
  - 284 FILL writes, then ARMED and POST writes.
  - capture_done after exactly 100 post-trigger writes.
  - oldest_addr equals the final pointer value.
- Long ARMED dwell (1000 samples before trig):
  - waddr wraps 383->0 repeatedly and never reaches 384.
  - With CAPT_TRIG_CNT_EN defined, trig_cnt=1000.
- trig pulses during FILL -> ignored; armed rises only after ENTRIES-post_len samples.
- trig coincident with smpl_en in ARMED, post_len=1 -> that single write completes capture; capture_done next edge; no further we.
- post_len=0 -> trig in ARMED goes to DONE directly; post_len=500 -> clamped to 383, so FILL needs 1 sample.
- rst asserted mid-POST -> all outputs 0 immediately; a subsequent run restarts cleanly at waddr=0.

Source files
------------

// File: rtl/capture_if.sv
// Sample-stream and queue-write-port bundle for capture_ctrl.
// The master drives the stream and control inputs; the slave is the controller.
interface capture_if #(
    parameter int LOG2   = 9,
    parameter int DATA_W = 8
);
    logic              run;
    logic [LOG2-1:0]   post_len;
    logic              smpl_en;
    logic [DATA_W-1:0] smpl;
    logic              trig;
    logic              we;
    logic [LOG2-1:0]   waddr;
    logic [DATA_W-1:0] wdata;
    logic              armed;
    logic              capture_done;
    logic [LOG2-1:0]   oldest_addr;
    logic [15:0]       trig_cnt;

    modport master (
        output run, post_len, smpl_en, smpl, trig,
        input  we, waddr, wdata, armed, capture_done, oldest_addr, trig_cnt
    );

    modport slave (
        input  run, post_len, smpl_en, smpl, trig,
        output we, waddr, wdata, armed, capture_done, oldest_addr, trig_cnt
    );
endinterface

// File: rtl/capture_ctrl.sv
// Write-side controller for the circular sample queue: fill / armed / post-trigger capture.
// Define CAPT_TRIG_CNT_EN to build the saturating count of samples written while armed.
module capture_ctrl #(
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9,
    parameter int DATA_W  = 8
) (
    input logic      clk,
    input logic      rst,
    capture_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_POST, S_DONE} state_t;

    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);
    localparam logic [LOG2-1:0] ONE  = LOG2'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LOG2-1:0]     r_ptr;
    logic [LOG2-1:0]     r_fill_cnt;
    logic [LOG2-1:0]     r_post_cnt;
    logic [LOG2-1:0]     r_post_len;
    logic [LOG2-1:0]     w_fill_target;
    logic                w_wr;
    logic                w_start;
    logic                r_we_p1;
    logic [LOG2-1:0]     r_waddr_p1;
    logic [DATA_W-1:0]   r_wdata_p1;

    function automatic logic [LOG2-1:0] ptr_inc(input logic [LOG2-1:0] p);
        return (p == LAST) ? '0 : p + ONE;
    endfunction

    function automatic logic [LOG2-1:0] clamp_len(input logic [LOG2-1:0] l);
        return (l > LAST) ? LAST : l;
    endfunction

    // Pre-trigger history needed before arming; post_len is clamped so this is never zero.
    assign w_fill_target = LOG2'(ENTRIES) - r_post_len;
    assign w_start       = bus.run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        if (bus.run) begin
            w_state_nxt = S_FILL;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (bus.smpl_en) begin
                        w_wr = 1'b1;
                        if (r_fill_cnt + ONE == w_fill_target) w_state_nxt = S_ARMED;
                    end
                end
                S_ARMED: begin
                    w_wr = bus.smpl_en;
                    // A sample coincident with trig is the first post-trigger sample.
                    if (bus.trig) begin
                        if (r_post_len == '0 || (r_post_len == ONE && bus.smpl_en))
                            w_state_nxt = S_DONE;
                        else
                            w_state_nxt = S_POST;
                    end
                end
                S_POST: begin
                    if (bus.smpl_en) begin
                        w_wr = 1'b1;
                        if (r_post_cnt + ONE == r_post_len) w_state_nxt = S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1: registered queue write port, one cycle behind the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we_p1    <= 1'b0;
            r_waddr_p1 <= '0;
            r_wdata_p1 <= '0;
            r_ptr      <= '0;
            r_fill_cnt <= '0;
            r_post_cnt <= '0;
            r_post_len <= '0;
        end else begin
            r_we_p1 <= w_wr;
            if (w_wr) begin
                r_waddr_p1 <= r_ptr;
                r_wdata_p1 <= bus.smpl;
                r_ptr      <= ptr_inc(r_ptr);
            end
            if (w_start) begin
                r_ptr      <= '0;
                r_fill_cnt <= '0;
                r_post_cnt <= '0;
                r_post_len <= clamp_len(bus.post_len);
            end else begin
                if (r_state == S_FILL && w_wr) r_fill_cnt <= r_fill_cnt + ONE;
                if (r_state == S_ARMED)        r_post_cnt <= bus.smpl_en ? ONE : '0;
                if (r_state == S_POST && w_wr) r_post_cnt <= r_post_cnt + ONE;
            end
        end
    end

`ifdef CAPT_TRIG_CNT_EN
    logic [15:0] r_trig_cnt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           r_trig_cnt <= '0;
        else if (w_start)                  r_trig_cnt <= '0;
        else if (r_state == S_ARMED && w_wr) r_trig_cnt <= sat_inc16(r_trig_cnt);
    end

    assign bus.trig_cnt = r_trig_cnt;
`else
    assign bus.trig_cnt = '0;
`endif

    assign bus.we           = r_we_p1;
    assign bus.waddr        = r_waddr_p1;
    assign bus.wdata        = r_wdata_p1;
    assign bus.armed        = (r_state == S_ARMED);
    assign bus.capture_done = (r_state == S_DONE);
    // The next slot to be overwritten holds the oldest sample.
    assign bus.oldest_addr  = (r_state == S_DONE) ? r_ptr : '0;
endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: randomized captures against a count-based reference model.
module tb_capture_ctrl;
    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    capture_if #(.LOG2(LOG2), .DATA_W(8)) bus ();

    capture_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Reference model state, expressed as sample counts since the last run.
    bit  m_started = 0;
    bit  m_done    = 0;
    bit  m_trg     = 0;
    int  m_n       = 0;
    int  m_post    = 0;
    int  m_L       = 0;
    int  m_tc      = 0;
    bit  m_ph_armed;

    function automatic void check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic bit exp_armed();
        return m_started && !m_trg && !m_done && (m_n >= ENTRIES - m_L);
    endfunction

    function automatic int exp_oldest();
        return m_done ? (m_n % ENTRIES) : 0;
    endfunction

    function automatic int exp_tc();
`ifdef CAPT_TRIG_CNT_EN
        return m_tc;
`else
        return 0;
`endif
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_started = 0; m_done = 0; m_trg = 0;
                m_n = 0; m_post = 0; m_L = 0; m_tc = 0;
                exp_q.delete();
            end else if (bus.run) begin
                m_started = 1; m_done = 0; m_trg = 0;
                m_n = 0; m_post = 0; m_tc = 0;
                m_L = (int'(bus.post_len) > ENTRIES - 1) ? ENTRIES - 1 : int'(bus.post_len);
            end else if (m_started && !m_done) begin
                m_ph_armed = !m_trg && (m_n >= ENTRIES - m_L);
                if (bus.smpl_en) begin
                    exp_q.push_back('{addr: m_n % ENTRIES, data: int'(bus.smpl)});
                    m_n++;
                    if (m_ph_armed && m_tc < 65535) m_tc++;
                    if (m_trg) m_post++;
                end
                if (m_ph_armed && bus.trig) begin
                    m_trg  = 1;
                    m_post = bus.smpl_en ? 1 : 0;
                end
                if (m_trg && m_post >= m_L) m_done = 1;
            end
        end
    end

    wr_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.we) begin
                    check("waddr_in_range", int'(bus.waddr < LOG2'(ENTRIES)), 1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_we", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("waddr", int'(bus.waddr), mon_e.addr);
                        check("wdata", int'(bus.wdata), mon_e.data);
                    end
                end
                if (exp_q.size() != 0) begin
                    check("missing_we", exp_q.size(), 0);
                    exp_q.delete();
                end
                check("armed", int'(bus.armed), int'(exp_armed()));
                check("capture_done", int'(bus.capture_done), int'(m_done));
                check("oldest_addr", int'(bus.oldest_addr), exp_oldest());
                check("trig_cnt", int'(bus.trig_cnt), exp_tc());
            end
        end
    end

    task automatic capture(input int pl, input int dwell, input int en_pct, input bit coin,
                           input int noise_pct);
        int total_en;
        int armed_smpls;
        int cyc;
        int tc_exp;
        bus.post_len = LOG2'(pl);
        bus.run      = 1'b1;
        bus.smpl_en  = 1'b0;
        bus.trig     = 1'b0;
        @(negedge clk);
        bus.run     = 1'b0;
        total_en    = 0;
        armed_smpls = 0;
        cyc         = 0;
        while (!m_done && cyc < 20000) begin
            bus.smpl = 8'($urandom);
            if (exp_armed() && armed_smpls >= dwell) begin
                bus.trig    = 1'b1;
                bus.smpl_en = coin;
            end else begin
                bus.smpl_en = ($urandom_range(99) < en_pct);
                bus.trig    = exp_armed() ? 1'b0 : ($urandom_range(99) < noise_pct);
                if (exp_armed() && bus.smpl_en) armed_smpls++;
            end
            if (bus.smpl_en) total_en++;
            @(negedge clk);
            cyc++;
        end
        bus.smpl_en = 1'b0;
        bus.trig    = 1'b0;
        if (cyc >= 20000) begin
            check("capture_timeout", 0, 1);
        end else begin
            check("oldest_vs_sample_count", int'(bus.oldest_addr), total_en % ENTRIES);
`ifdef CAPT_TRIG_CNT_EN
            tc_exp = (dwell + coin > 65535) ? 65535 : dwell + coin;
`else
            tc_exp = 0;
`endif
            check("trig_cnt_final", int'(bus.trig_cnt), tc_exp);
        end
        // DONE must hold and ignore further strobes and triggers.
        repeat (6) begin
            bus.smpl_en = $urandom_range(1);
            bus.trig    = $urandom_range(1);
            bus.smpl    = 8'($urandom);
            @(negedge clk);
        end
        bus.smpl_en = 1'b0;
        bus.trig    = 1'b0;
        check("done_held", int'(bus.capture_done), (cyc >= 20000) ? 0 : 1);
    endtask

    initial begin
        int cyc;
        bus.run      = 1'b0;
        bus.post_len = '0;
        bus.smpl_en  = 1'b0;
        bus.smpl     = '0;
        bus.trig     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_we", int'(bus.we), 0);
        check("reset_waddr", int'(bus.waddr), 0);
        check("reset_armed", int'(bus.armed), 0);
        check("reset_done", int'(bus.capture_done), 0);
        check("reset_trig_cnt", int'(bus.trig_cnt), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        capture(100, 1, 100, 1'b0, 0);
        capture(100, 1000, 100, 1'b0, 0);
        capture(60, 5, 70, 1'b0, 40);
        capture(1, 3, 100, 1'b1, 0);
        capture(0, 4, 100, 1'b1, 0);
        capture(500, 2, 100, 1'b0, 0);

        // Restart partway through FILL.
        bus.post_len = LOG2'(200);
        bus.run      = 1'b1;
        @(negedge clk);
        bus.run     = 1'b0;
        bus.smpl_en = 1'b1;
        repeat (40) begin
            bus.smpl = 8'($urandom);
            @(negedge clk);
        end
        bus.smpl_en = 1'b0;
        capture(200, 3, 90, 1'b1, 10);

        // Reset in the middle of POST, then a clean restart.
        bus.post_len = LOG2'(50);
        bus.run      = 1'b1;
        @(negedge clk);
        bus.run     = 1'b0;
        bus.smpl_en = 1'b1;
        cyc = 0;
        while (!(m_trg && m_post >= 10) && cyc < 2000) begin
            bus.smpl = 8'($urandom);
            bus.trig = exp_armed();
            @(negedge clk);
            cyc++;
        end
        bus.trig = 1'b0;
        if (cyc >= 2000) check("reach_post_timeout", 0, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_we", int'(bus.we), 0);
        check("rst_waddr", int'(bus.waddr), 0);
        check("rst_wdata", int'(bus.wdata), 0);
        check("rst_armed", int'(bus.armed), 0);
        check("rst_done", int'(bus.capture_done), 0);
        check("rst_oldest", int'(bus.oldest_addr), 0);
        check("rst_trig_cnt", int'(bus.trig_cnt), 0);
        @(negedge clk);
        bus.smpl_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        capture(30, 2, 100, 1'b0, 0);

        for (int i = 0; i < 6; i++) begin
            capture($urandom_range(511), $urandom_range(40), $urandom_range(100, 30),
                    1'($urandom_range(1)), $urandom_range(30));
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
